// File: rtl/fadd_param.sv
// Parametrised multi-cycle floating-point adder/subtractor.
// One operation in flight: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE.
// Handshake: start is sampled only while ready=1. ready=1 means the unit is
// idle and sum/flags hold the last result. A start seen while ready=0 is
// dropped. The result appears exactly four edges after the issuing edge.
module fadd_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic                   ready,
    output logic [3:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;                  // hidden, mantissa, guard, round, sticky
    localparam int EW = EXP_W + $clog2(SW) + 2;     // signed working exponent
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic signed [EW-1:0] EMAX_E = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {RESET, IDLE, ALIGN, ADDSUB, NORM, ROUND} state_t;
    state_t state;

    // Operand and stage registers; only one operation is ever in flight.
    logic [W-1:0]            a_r, b_r;
    logic                    op_r;
    logic                    al_special;
    logic [W-1:0]            al_spec_res;
    logic [3:0]              al_spec_flags;
    logic                    al_sign_big, al_sign_small;
    logic [EXP_W-1:0]        al_exp;
    logic [SW-1:0]           al_big, al_small;
    logic [SW:0]             mag_r;
    logic [SW-1:0]           norm_r;
    logic signed [EW-1:0]    exp_n;

    // ALIGN combinational signals
    logic                    sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_gt;
    logic [EXP_W-1:0]        ea, eb, big_e, small_e, diff;
    logic [MAN_W-1:0]        ma, mb, big_m, small_m;
    logic [SW-1:0]           small_full, shifted, small_al;
    logic                    lost, spec_v;
    logic [W-1:0]            spec_res_v;
    logic [3:0]              spec_flags_v;

    // ALIGN: classify operands, resolve special cases, align the smaller magnitude.
    always_comb begin
        sa      = a_r[W-1];
        ea      = a_r[W-2:MAN_W];
        ma      = a_r[MAN_W-1:0];
        sb      = b_r[W-1] ^ op_r;
        eb      = b_r[W-2:MAN_W];
        mb      = b_r[MAN_W-1:0];
        a_zero  = (ea == '0);                       // subnormals flush to signed zero
        b_zero  = (eb == '0);
        a_inf   = (ea == EXP_ONES) && (ma == '0);
        b_inf   = (eb == EXP_ONES) && (mb == '0);
        a_nan   = (ea == EXP_ONES) && (ma != '0);
        b_nan   = (eb == EXP_ONES) && (mb != '0);
        a_gt    = {ea, ma} >= {eb, mb};
        big_e   = a_gt ? ea : eb;
        big_m   = a_gt ? ma : mb;
        small_e = a_gt ? eb : ea;
        small_m = a_gt ? mb : ma;
        diff    = big_e - small_e;
        small_full = {1'b1, small_m, 3'b000};
        if (32'(diff) >= SW) begin
            shifted = '0;
            lost    = 1'b1;
        end else begin
            shifted = small_full >> diff;
            lost    = |(small_full & ~({SW{1'b1}} << diff));
        end
        small_al = {shifted[SW-1:1], shifted[0] | lost};

        spec_v       = 1'b1;
        spec_res_v   = '0;
        spec_flags_v = '0;
        if (a_nan || b_nan) begin
            spec_res_v = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_res_v   = QNAN;
            spec_flags_v = 4'b1000;
        end else if (a_inf) begin
            spec_res_v = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res_v = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_res_v = {sa & sb, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_res_v = a_r;
        end else if (a_zero) begin
            spec_res_v = {sb, b_r[W-2:0]};
        end else begin
            spec_v = 1'b0;
        end
    end

    // ADDSUB: add magnitudes on equal signs, else subtract smaller from larger.
    logic [SW:0] mag_v;
    always_comb begin
        if (al_sign_big == al_sign_small)
            mag_v = {1'b0, al_big} + {1'b0, al_small};
        else
            mag_v = {1'b0, al_big} - {1'b0, al_small};
    end

    // NORM: right shift on carry-out, else leading-one left shift in one step.
    int                   lz;
    logic [SW-1:0]        norm_v;
    logic signed [EW-1:0] exp_base, exp_v;
    always_comb begin
        lz = 0;
        for (int i = 0; i < SW; i++)
            if (mag_r[i]) lz = SW - 1 - i;
        exp_base = EW'(al_exp);
        if (mag_r[SW]) begin
            norm_v = {mag_r[SW:2], mag_r[1] | mag_r[0]};
            exp_v  = exp_base + ONE_E;
        end else begin
            norm_v = mag_r[SW-1:0] << lz;
            exp_v  = exp_base - EW'(lz);
        end
    end

    // ROUND: nearest-even on guard/round/sticky, then range and special selection.
    logic                 g, r, s, lsb, up, inexact;
    logic [MAN_W+1:0]     man_up;
    logic [MAN_W-1:0]     man_f;
    logic signed [EW-1:0] exp_f;
    logic [W-1:0]         res_v;
    logic [3:0]           fl_v;
    always_comb begin
        lsb     = norm_r[3];
        g       = norm_r[2];
        r       = norm_r[1];
        s       = norm_r[0];
        up      = g & (r | s | lsb);
        inexact = g | r | s;
        man_up  = {1'b0, norm_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
        if (man_up[MAN_W+1]) begin
            exp_f = exp_n + ONE_E;
            man_f = man_up[MAN_W:1];
        end else begin
            exp_f = exp_n;
            man_f = man_up[MAN_W-1:0];
        end
        if (al_special) begin
            res_v = al_spec_res;
            fl_v  = al_spec_flags;
        end else if (mag_r == '0) begin
            res_v = '0;                             // exact cancellation gives +0
            fl_v  = '0;
        end else if (exp_f >= EMAX_E) begin
            res_v = {al_sign_big, EXP_ONES, {MAN_W{1'b0}}};
            fl_v  = 4'b0101;
        end else if (exp_f <= ZERO_E) begin
            res_v = {al_sign_big, {(W-1){1'b0}}};
            fl_v  = 4'b0011;
        end else begin
            res_v = {al_sign_big, exp_f[EXP_W-1:0], man_f};
            fl_v  = {3'b000, inexact};
        end
    end

    // Control FSM and stage registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state         <= RESET;
            sum           <= '0;
            flags         <= '0;
            ready         <= 1'b0;
            a_r           <= '0;
            b_r           <= '0;
            op_r          <= 1'b0;
            al_special    <= 1'b0;
            al_spec_res   <= '0;
            al_spec_flags <= '0;
            al_sign_big   <= 1'b0;
            al_sign_small <= 1'b0;
            al_exp        <= '0;
            al_big        <= '0;
            al_small      <= '0;
            mag_r         <= '0;
            norm_r        <= '0;
            exp_n         <= '0;
        end else begin
            case (state)
                RESET: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        ready <= 1'b0;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    al_special    <= spec_v;
                    al_spec_res   <= spec_res_v;
                    al_spec_flags <= spec_flags_v;
                    al_sign_big   <= a_gt ? sa : sb;
                    al_sign_small <= a_gt ? sb : sa;
                    al_exp        <= big_e;
                    al_big        <= {1'b1, big_m, 3'b000};
                    al_small      <= small_al;
                    state         <= ADDSUB;
                end
                ADDSUB: begin
                    mag_r <= mag_v;
                    state <= NORM;
                end
                NORM: begin
                    norm_r <= norm_v;
                    exp_n  <= exp_v;
                    state  <= ROUND;
                end
                ROUND: begin
                    sum   <= res_v;
                    flags <= fl_v;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= RESET;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fadd_param.sv
// Bench for fadd_param: bfloat16 instance plus a half-precision instance.
// Drivers push {flags, sum} expectations; monitors pop them on each result.
module tb_fadd_param;
    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic        start = 1'b0, op = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [15:0] sum;
    logic        ready;
    logic [3:0]  flags;

    logic        start_h = 1'b0, op_h = 1'b0;
    logic [15:0] a_h = '0, b_h = '0;
    logic [15:0] sum_h;
    logic        ready_h;
    logic [3:0]  flags_h;

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_h_q[$];

    fadd_param dut (
        .clock(clock), .nreset(nreset), .start(start), .op(op),
        .a(a), .b(b), .sum(sum), .ready(ready), .flags(flags)
    );

    fadd_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clock(clock), .nreset(nreset), .start(start_h), .op(op_h),
        .a(a_h), .b(b_h), .sum(sum_h), .ready(ready_h), .flags(flags_h)
    );

    // clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // monitor for the bfloat16 instance
    logic        pend = 1'b0;
    int          lat = 0;
    logic [19:0] e;
    always @(negedge clock) begin
        if (!nreset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (!ready) lat++;
                else begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %h with nothing expected", {flags, sum});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {flags, sum}, e);
                        check("latency", 20'(lat), 20'd4);
                    end
                end
            end
            if (ready && start) begin
                pend = 1'b1;
                lat  = 0;
            end
        end
    end

    // monitor for the half-precision instance
    logic        pend_h = 1'b0;
    logic [19:0] e_h;
    always @(negedge clock) begin
        if (!nreset) begin
            pend_h = 1'b0;
        end else begin
            if (pend_h && ready_h) begin
                pend_h = 1'b0;
                if (exp_h_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result_h: got %h with nothing expected", {flags_h, sum_h});
                end else begin
                    e_h = exp_h_q.pop_front();
                    check("result_h", {flags_h, sum_h}, e_h);
                end
            end
            if (ready_h && start_h) pend_h = 1'b1;
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                         input logic [19:0] ex);
        int n = 0;
        while (!ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: ready=%b, required 1", ready);
        end
        a = ta; b = tb; op = top; start = 1'b1;
        exp_q.push_back(ex);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic issue_h(input logic [15:0] ta, input logic [15:0] tb, input logic [19:0] ex);
        int n = 0;
        while (!ready_h && n < 50) begin
            @(posedge clock); #1; n++;
        end
        a_h = ta; b_h = tb; op_h = 1'b0; start_h = 1'b1;
        exp_h_q.push_back(ex);
        @(posedge clock); #1;
        start_h = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp_h_q.size() != 0 || !ready) && n < 200) begin
            @(posedge clock); #1; n++;
        end
        check(name, 20'(exp_q.size() + exp_h_q.size()), 20'd0);
    endtask

    // directed vectors: {a, b, op, flags, sum}
    localparam int NV = 15;
    logic [52:0] vecs [NV] = '{
        {16'h3F8C, 16'h3FC0, 1'b0, 4'h0, 16'h4026},
        {16'h4020, 16'h3F80, 1'b1, 4'h0, 16'h3FC0},
        {16'hBF80, 16'h3F80, 1'b0, 4'h0, 16'h0000},
        {16'h3F80, 16'h3B80, 1'b0, 4'h1, 16'h3F80},
        {16'h3F81, 16'h3B80, 1'b0, 4'h1, 16'h3F82},
        {16'h8000, 16'h0000, 1'b0, 4'h0, 16'h0000},
        {16'h0000, 16'h8000, 1'b0, 4'h0, 16'h0000},
        {16'h8000, 16'h8000, 1'b0, 4'h0, 16'h8000},
        {16'hFFFF, 16'hBF80, 1'b0, 4'h0, 16'h7FC0},
        {16'hFF80, 16'hBF80, 1'b0, 4'h0, 16'hFF80},
        {16'h7F80, 16'hFF80, 1'b0, 4'h8, 16'h7FC0},
        {16'h7F7F, 16'h7F7F, 1'b0, 4'h5, 16'h7F80},
        {16'h3FC0, 16'h0000, 1'b0, 4'h0, 16'h3FC0},
        {16'h0100, 16'h00FF, 1'b1, 4'h3, 16'h0000},
        {16'h3F80, 16'hBF80, 1'b1, 4'h0, 16'h4000}
    };

    initial begin
        logic [52:0] v;
        // reset and first ready
        #2 nreset = 1'b0;
        #1;
        check("reset_out", {flags, sum}, 20'h0);
        check("reset_ready", 20'(ready), 20'd0);
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        check("ready_before_edge", 20'(ready), 20'd0);
        @(posedge clock); #1;
        check("ready_after_edge", 20'(ready), 20'd1);

        // first operation with an ignored start pulse while busy
        issue(16'h3F80, 16'h3FC0, 1'b0, {4'h0, 16'h4020});
        a = 16'h7F7F; b = 16'h7F7F; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        drain("drain_first");
        repeat (3) @(posedge clock);
        #1 check("hold_result", {flags, sum}, {4'h0, 16'h4020});

        // directed vector table
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            issue(v[52:37], v[36:21], v[20], v[19:0]);
        end
        drain("drain_table");

        // abort: reset two cycles after start
        issue(16'h3F80, 16'h3FC0, 1'b0, {4'h0, 16'h4020});
        @(posedge clock); #1;
        nreset = 1'b0;
        #1;
        check("abort_out", {flags, sum}, 20'h0);
        check("abort_ready", 20'(ready), 20'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        @(posedge clock); #1;
        check("abort_ready_rise", 20'(ready), 20'd1);
        repeat (8) @(posedge clock);
        #1 check("abort_no_stale", {flags, sum}, 20'h0);

        // half-precision instance
        issue_h(16'h3C00, 16'h3C00, {4'h0, 16'h4000});
        issue_h(16'h3C00, 16'h3800, {4'h0, 16'h3E00});
        drain("drain_half");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
